// File: rtl/gfx_state_writer.sv
// Shadow register file for game objects; on each vblank it streams the words changed since the
// previous frame onto the graphics register bus, lowest address first, one per granted cycle.
module gfx_state_writer #(
  parameter int unsigned NUM_REGS = 10,
  parameter logic [3:0]  GFX_CS   = 4'b0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        vblank_start,
  input  logic        force_all,
  input  logic        bus_grant,
  output logic [3:0]  chipselect,
  output logic [3:0]  data_address,
  output logic [15:0] databus,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int NR = int'(NUM_REGS);

  typedef enum logic [1:0] {StIdle, StSend, StEmpty} state_e;

  state_e              r_state;
  logic [15:0]         r_shadow [NUM_REGS];
  logic [15:0]         r_snap   [NUM_REGS];
  logic [NUM_REGS-1:0] r_dirty;
  logic [NUM_REGS-1:0] r_mask;
  logic [3:0]          r_chipselect;
  logic [3:0]          r_addr;
  logic [15:0]         r_databus;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_overrun;

  logic                w_wr_valid;
  logic                w_start;
  logic [NUM_REGS-1:0] w_snap_mask;
  logic [NUM_REGS-1:0] w_dirty_d;
  logic [NUM_REGS-1:0] w_onehot;
  logic [NUM_REGS-1:0] w_rest;
  logic [3:0]          w_first_idx;
  logic [3:0]          w_next_idx;

  // Priority encoder: index of the lowest set bit, 0 when the mask is empty.
  function automatic logic [3:0] lowest_set(input logic [NUM_REGS-1:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_comb begin
    w_wr_valid  = wr_en && (32'(wr_addr) < NUM_REGS);
    w_start     = (r_state == StIdle) && vblank_start;
    w_snap_mask = force_all ? '1 : r_dirty;
    w_first_idx = lowest_set(w_snap_mask);

    // A write on the snapshot edge survives the clear and stays pending for the next frame.
    w_dirty_d = w_start ? '0 : r_dirty;
    if (w_wr_valid) w_dirty_d[wr_addr] = 1'b1;

    w_onehot         = '0;
    w_onehot[r_addr] = 1'b1;
    w_rest           = r_mask & ~w_onehot;
    w_next_idx       = lowest_set(w_rest);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dirty <= '1;
      for (int i = 0; i < NR; i++) r_shadow[i] <= '0;
    end else begin
      r_dirty <= w_dirty_d;
      if (w_wr_valid) r_shadow[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_mask       <= '0;
      r_chipselect <= '0;
      r_addr       <= '0;
      r_databus    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < NR; i++) r_snap[i] <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (vblank_start && r_busy) r_overrun <= 1'b1;

      case (r_state)
        StIdle: begin
          if (vblank_start) begin
            r_snap <= r_shadow;
            r_busy <= 1'b1;
            if (w_snap_mask == '0) begin
              r_state <= StEmpty;
            end else begin
              // The snapshot is loading this edge, so the first word comes from the shadow.
              r_mask       <= w_snap_mask;
              r_chipselect <= GFX_CS;
              r_addr       <= w_first_idx;
              r_databus    <= r_shadow[w_first_idx];
              r_state      <= StSend;
            end
          end
        end

        StEmpty: begin
          r_busy       <= 1'b0;
          r_frame_done <= 1'b1;
          r_state      <= StIdle;
        end

        StSend: begin
          if (bus_grant) begin
            if (w_rest != '0) begin
              r_mask    <= w_rest;
              r_addr    <= w_next_idx;
              r_databus <= r_snap[w_next_idx];
            end else begin
              r_mask       <= '0;
              r_chipselect <= '0;
              r_addr       <= '0;
              r_databus    <= '0;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= StIdle;
            end
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign chipselect   = r_chipselect;
  assign data_address = r_addr;
  assign databus      = r_databus;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_gfx_state_writer.sv
// Directed bench for gfx_state_writer: records every completed bus write and checks it per scenario.
module tb_gfx_state_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        vblank_start;
  logic        force_all;
  logic        bus_grant;
  logic [3:0]  chipselect;
  logic [3:0]  data_address;
  logic [15:0] databus;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int n_pass  = 0;
  int n_total = 0;

  logic [19:0] q_log [$];

  gfx_state_writer #(
    .NUM_REGS(10),
    .GFX_CS  (4'b0001)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .vblank_start(vblank_start),
    .force_all   (force_all),
    .bus_grant   (bus_grant),
    .chipselect  (chipselect),
    .data_address(data_address),
    .databus     (databus),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Completed transfers: values seen just before the edge that accepts them.
  always @(posedge clk) begin
    if (!rst && chipselect != 4'd0 && bus_grant) q_log.push_back({data_address, databus});
  end

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_vblank(input logic f);
    vblank_start = 1'b1; force_all = f;
    @(negedge clk);
    vblank_start = 1'b0; force_all = 1'b0;
  endtask

  task automatic run_frame(output int cycles, output logic done_seen);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    done_seen = frame_done;
  endtask

  task automatic test_reset();
    n_total++;
    if ({chipselect, data_address, databus, busy, frame_done, overrun} !== 27'd0) begin
      $display("FAIL reset_outputs: got cs=%0h a=%0h d=%0h b=%0b fd=%0b ov=%0b required all 0",
               chipselect, data_address, databus, busy, frame_done, overrun);
    end else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_post_reset_frame();
    int cyc; logic done; logic ok;
    bus_grant = 1'b1;
    q_log.delete();
    pulse_vblank(1'b0);
    n_total++;
    if (chipselect !== 4'b0001 || data_address !== 4'd0 || busy !== 1'b1) begin
      $display("FAIL first_word: got cs=%0h a=%0h b=%0b required cs=1 a=0 b=1",
               chipselect, data_address, busy);
    end else n_pass++;
    run_frame(cyc, done);
    n_total++;
    if (cyc !== 10) $display("FAIL post_reset_busy: got %0d cycles required 10", cyc);
    else n_pass++;
    n_total++;
    if (done !== 1'b1) $display("FAIL post_reset_done: got %0b required 1", done);
    else n_pass++;
    ok = (q_log.size() == 10);
    for (int i = 0; i < q_log.size() && ok; i++) ok = (q_log[i] == {4'(i), 16'd0});
    n_total++;
    if (!ok) $display("FAIL post_reset_writes: got %0d writes required 10 of (i,0)", q_log.size());
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (frame_done !== 1'b0) $display("FAIL done_one_cycle: got %0b required 0", frame_done);
    else n_pass++;
  endtask

  task automatic test_delta();
    int cyc; logic done;
    write_word(4'd4, 16'd305);
    write_word(4'd6, 16'd500);
    write_word(4'd12, 16'hDEAD);
    q_log.delete();
    pulse_vblank(1'b0);
    run_frame(cyc, done);
    n_total++;
    if (q_log.size() != 2 || q_log[0] !== {4'd4, 16'd305} || q_log[1] !== {4'd6, 16'd500})
      $display("FAIL delta_writes: got %0d writes first=%0h required 2 writes (4,305),(6,500)",
               q_log.size(), (q_log.size() > 0) ? q_log[0] : 20'h0);
    else n_pass++;
    n_total++;
    if (cyc !== 2) $display("FAIL delta_busy: got %0d cycles required 2", cyc);
    else n_pass++;
    q_log.delete();
    pulse_vblank(1'b0);
    run_frame(cyc, done);
    n_total++;
    if (q_log.size() != 0) $display("FAIL empty_writes: got %0d writes required 0", q_log.size());
    else n_pass++;
    n_total++;
    if (cyc !== 1 || done !== 1'b1)
      $display("FAIL empty_done: got busy=%0d done=%0b required busy=1 done=1", cyc, done);
    else n_pass++;
  endtask

  task automatic test_grant_stall();
    int cyc; logic done; logic ok;
    write_word(4'd2, 16'h00C8);
    bus_grant = 1'b0;
    q_log.delete();
    pulse_vblank(1'b0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (chipselect !== 4'd1 || data_address !== 4'd2 || databus !== 16'h00C8) ok = 1'b0;
      @(negedge clk);
    end
    n_total++;
    if (!ok) $display("FAIL stall_stable: got cs=%0h a=%0h d=%0h required 1/2/00c8",
                      chipselect, data_address, databus);
    else n_pass++;
    bus_grant = 1'b1;
    run_frame(cyc, done);
    n_total++;
    if (q_log.size() != 1 || q_log[0] !== {4'd2, 16'h00C8})
      $display("FAIL stall_writes: got %0d writes required 1 of (2,00c8)", q_log.size());
    else n_pass++;
  endtask

  task automatic test_collision();
    int cyc; logic done;
    write_word(4'd3, 16'd1);
    q_log.delete();
    vblank_start = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'd7;
    @(negedge clk);
    vblank_start = 1'b0; wr_en = 1'b0;
    run_frame(cyc, done);
    n_total++;
    if (q_log.size() != 1 || q_log[0] !== {4'd3, 16'd1})
      $display("FAIL collision_old: got %0d writes first=%0h required (3,1)",
               q_log.size(), (q_log.size() > 0) ? q_log[0] : 20'h0);
    else n_pass++;
    q_log.delete();
    pulse_vblank(1'b0);
    run_frame(cyc, done);
    n_total++;
    if (q_log.size() != 1 || q_log[0] !== {4'd3, 16'd7})
      $display("FAIL collision_new: got %0d writes first=%0h required (3,7)",
               q_log.size(), (q_log.size() > 0) ? q_log[0] : 20'h0);
    else n_pass++;
  endtask

  task automatic test_overrun_force();
    int cyc; logic done; logic ok;
    logic [15:0] exp_val [10];
    exp_val = '{16'd0, 16'd0, 16'h00C8, 16'd7, 16'd305, 16'h0055, 16'd500, 16'd0, 16'd0, 16'd0};
    write_word(4'd5, 16'h0055);
    bus_grant = 1'b0;
    q_log.delete();
    pulse_vblank(1'b0);
    n_total++;
    if (overrun !== 1'b0) $display("FAIL overrun_early: got %0b required 0", overrun);
    else n_pass++;
    pulse_vblank(1'b0);
    n_total++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %0b required 1", overrun);
    else n_pass++;
    bus_grant = 1'b1;
    run_frame(cyc, done);
    n_total++;
    if (q_log.size() != 1 || q_log[0] !== {4'd5, 16'h0055})
      $display("FAIL overrun_frame: got %0d writes required 1 of (5,0055)", q_log.size());
    else n_pass++;
    q_log.delete();
    pulse_vblank(1'b1);
    run_frame(cyc, done);
    ok = (q_log.size() == 10);
    for (int i = 0; i < q_log.size() && ok; i++) ok = (q_log[i] == {4'(i), exp_val[i]});
    n_total++;
    if (!ok) $display("FAIL force_all: got %0d writes required 10 matching shadow", q_log.size());
    else n_pass++;
    n_total++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %0b required 1", overrun);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int cyc; logic done; logic ok;
    write_word(4'd1, 16'h0011);
    bus_grant = 1'b0;
    pulse_vblank(1'b0);
    n_total++;
    if (chipselect !== 4'd1 || busy !== 1'b1)
      $display("FAIL pre_reset_send: got cs=%0h b=%0b required cs=1 b=1", chipselect, busy);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++;
    if (chipselect !== 4'd0 || busy !== 1'b0 || overrun !== 1'b0)
      $display("FAIL async_release: got cs=%0h b=%0b ov=%0b required 0/0/0",
               chipselect, busy, overrun);
    else n_pass++;
    #1 rst = 1'b0;
    bus_grant = 1'b1;
    @(negedge clk);
    q_log.delete();
    pulse_vblank(1'b0);
    run_frame(cyc, done);
    ok = (q_log.size() == 10);
    for (int i = 0; i < q_log.size() && ok; i++) ok = (q_log[i] == {4'(i), 16'd0});
    n_total++;
    if (!ok) $display("FAIL reset_resend: got %0d writes required 10 of (i,0)", q_log.size());
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    vblank_start = 1'b0; force_all = 1'b0; bus_grant = 1'b0;
    @(negedge clk);
    test_reset();
    test_post_reset_frame();
    test_delta();
    test_grant_stall();
    test_collision();
    test_overrun_force();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gfx_state_writer.md
Name: gfx_state_writer

Overview:
- CPU-side writer for the graphics register bus (chipselect / databus / data_address); it is the counterpart of the receiver in the graphics ASIC.
- Game logic posts object words (paddle, ball, score, game state) into a local shadow register file at any time.
- On each vertical-blank pulse the block snapshots the words changed since the last frame and writes them to the graphics unit, one per granted bus cycle.
- Delta-only updates; the bus is idle outside vblank.

Parameters:
- NUM_REGS, 10, number of shadow words; addresses 0..NUM_REGS-1. Max 16.
- GFX_CS, 4'b0001, chipselect value driven during a graphics write.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- wr_en  in  1  game-logic write strobe to the shadow file
- wr_addr  in  4  shadow word index; writes with wr_addr >= NUM_REGS are ignored
- wr_data  in  16  shadow word value
- vblank_start  in  1  one-cycle pulse at the start of vertical blank
- force_all  in  1  level; when sampled with vblank_start, every word is sent this frame
- bus_grant  in  1  arbiter grant; a write completes on a clk edge where chipselect != 0 and bus_grant = 1
- chipselect  out  4  GFX_CS while a write is pending, else 0
- data_address  out  4  word index of the pending write
- databus  out  16  word value of the pending write
- busy  out  1  high from snapshot until the last word is accepted
- frame_done  out  1  one-cycle pulse after the final accepted write (or immediately if nothing is dirty)
- overrun  out  1  sticky; set when vblank_start arrives while busy; cleared only by rst

Behaviour:
- Reset (async): shadow words = 0; dirty mask = all ones, so the first frame sends everything; state IDLE. All outputs 0.
- Shadow write: on a clk edge with wr_en and a valid wr_addr, the word is updated and its dirty bit is set. Allowed in any state.
- IDLE, vblank_start=1 at edge N:
  - Copy the shadow into the snapshot.
  - Snapshot mask = dirty mask, or all ones if force_all=1.
  - Clear the dirty mask, except that a same-edge wr_en sets its bit and goes into the shadow only; that word stays pending for the next frame while the snapshot holds the old value.
  - busy=1 from edge N.
  - If the snapshot mask is 0, pulse frame_done at N+1, drop busy, and return to IDLE.
  - Otherwise go to SEND.
- SEND:
  - Outputs are registered and present the lowest-index set bit of the snapshot mask: chipselect=GFX_CS, data_address=index, databus=snapshot value. The first word is valid from edge N (visible during cycle N+1).
  - Outputs hold stable while bus_grant=0; there is no timeout.
  - On an edge with bus_grant=1: clear that mask bit and present the next lowest set bit on the same edge (back-to-back, one word per cycle).
  - After the last bit is accepted: chipselect/data_address/databus go to 0, busy=0, frame_done=1 for one cycle, state IDLE.
- Shadow writes during SEND never alter the snapshot.
- vblank_start while busy: ignored for transfer purposes; sets overrun. The dirty mask keeps accumulating.
- Reset mid-SEND: the bus is released immediately (async); all state returns to reset values.
- Words are sent in ascending address order; clean words cost zero cycles (priority encoder, no scan).

Test Plan:
- Post-reset frame: rst release, bus_grant=1, vblank_start pulse → 10 consecutive writes, addr 0..9, data 0, chipselect=4'b0001; frame_done 1 cycle after addr 9 is accepted; busy high for exactly 10 cycles.
- Delta update: write addr 4 = 16'd305 and addr 6 = 16'd500, then vblank → exactly two writes, (4,305) then (6,500); no writes on the next vblank; frame_done pulses 1 cycle after vblank.
- Grant stall: dirty addr 2 = 16'h00C8, bus_grant=0 for 5 cycles then 1 → chipselect/addr/data stable at 1/2/0x00C8 for all stalled cycles; one completed transfer.
- Collision: wr_en addr 3 = 16'd7 on the same edge as vblank, with addr 3 previously 16'd1 and dirty → frame sends (3,1); next vblank sends (3,7).
- Overrun/force: with bus_grant=0 during SEND, pulse vblank again → overrun=1 and stays 1; later force_all=1 with vblank → all 10 words resent.
- Async reset mid-SEND: assert rst between clk edges → chipselect=0, busy=0 immediately; the next vblank resends all 10 words.
